cla_sub_pipe: RTL and testbench

- Two-stage pipelined carry-lookahead subtractor: D = A - B - Bin, with borrow-out, signed-overflow and zero flags.
- Complementary block to the team's carry-lookahead adder: it performs the decrement direction on the same operand widths.
- Feeds difference terms into the multi-operand tree.
- Uses valid/ready handshakes on both sides so it can sit between buffered tree stages.

---
 rtl/cla_sub_pipe_if.sv | 26 ++
 rtl/cla_sub_pipe.sv | 163 ++++++++++++++++
 tb/tb_cla_sub_pipe.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_sub_pipe_if.sv
// Operand/result handshake bundle for the pipelined lookahead subtractor.
interface cla_sub_pipe_if #(
    parameter int M = 17
);
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/cla_sub_pipe.sv
// Two-stage carry-lookahead subtractor: diff = a - b - bin, with borrow, overflow and zero flags.
// Low LO bits resolve in stage 1, the remaining bits plus flags in stage 2.
module cla_sub_pipe_cla #(
    parameter int N = 8,
    parameter int G = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int NG = (N + G - 1) / G;

    logic [N-1:0]  p;
    logic [N-1:0]  g;
    logic [NG-1:0] gp;
    logic [NG-1:0] gg;
    logic [NG:0]   gc;

    assign p = x ^ y;
    assign g = x & y;

    for (genvar j = 0; j < NG; j++) begin : grp
        localparam int B = j * G;
        localparam int W = (N - B < G) ? (N - B) : G;
        logic [W-1:0] pj;
        logic [W-1:0] gj;
        logic [W-1:0] cj;
        logic         gpj;
        logic         ggj;

        assign pj = p[B +: W];
        assign gj = g[B +: W];

        always_comb begin
            gpj = 1'b1;
            ggj = 1'b0;
            for (int i = 0; i < W; i++) begin
                ggj = gj[i] | (pj[i] & ggj);
                gpj = gpj & pj[i];
            end
        end

        // Ripple only inside the group; the group carry-in comes from the lookahead below.
        always_comb begin
            cj    = '0;
            cj[0] = gc[j];
            for (int i = 1; i < W; i++) begin
                cj[i] = gj[i-1] | (pj[i-1] & cj[i-1]);
            end
        end

        assign gp[j]       = gpj;
        assign gg[j]       = ggj;
        assign sum[B +: W] = pj ^ cj;
    end

    // Each group carry is a flat sum of products over group P/G and cin.
    always_comb begin
        logic term;
        logic acc;
        logic t;
        gc   = '0;
        term = 1'b0;
        acc  = 1'b0;
        t    = 1'b0;
        for (int j = 0; j <= NG; j++) begin
            term = cin;
            for (int m = 0; m < j; m++) term = term & gp[m];
            acc = term;
            for (int k = 0; k < j; k++) begin
                t = gg[k];
                for (int m = k + 1; m < j; m++) t = t & gp[m];
                acc = acc | t;
            end
            gc[j] = acc;
        end
    end

    assign cout = gc[NG];
endmodule

module cla_sub_pipe #(
    parameter int M  = 17,
    parameter int G  = 4,
    parameter int LO = M / 2
) (
    input  logic           clk,
    input  logic           rst_n,
    cla_sub_pipe_if.slave  io
);
    localparam int HI = M - LO;

    logic [LO-1:0] d_lo;
    logic          c_lo;
    logic [HI-1:0] d_hi;
    logic          c_hi;
    logic [M-1:0]  d_full;

    logic          s1_valid;
    logic [LO-1:0] s1_d_lo;
    logic          s1_borrow;
    logic [HI-1:0] s1_a_hi;
    logic [HI-1:0] s1_b_hi;

    logic          s2_load;
    logic          s1_adv;
    logic          accept;

    cla_sub_pipe_cla #(.N(LO), .G(G)) u_lo (
        .x    (io.a[LO-1:0]),
        .y    (~io.b[LO-1:0]),
        .cin  (~io.bin),
        .sum  (d_lo),
        .cout (c_lo)
    );

    cla_sub_pipe_cla #(.N(HI), .G(G)) u_hi (
        .x    (s1_a_hi),
        .y    (~s1_b_hi),
        .cin  (~s1_borrow),
        .sum  (d_hi),
        .cout (c_hi)
    );

    assign d_full      = {d_hi, s1_d_lo};
    assign s2_load     = !io.out_valid || io.out_ready;
    assign s1_adv      = s1_valid && s2_load;
    assign io.in_ready = !s1_valid || s2_load;
    assign accept      = io.in_valid && io.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            io.out_valid <= 1'b0;
            io.diff      <= '0;
            io.bout      <= 1'b0;
            io.ovf       <= 1'b0;
            io.zero      <= 1'b0;
        end else begin
            if (accept)      s1_valid <= 1'b1;
            else if (s1_adv) s1_valid <= 1'b0;
            if (s2_load) io.out_valid <= s1_valid;
            if (s1_adv) begin
                io.diff <= d_full;
                io.bout <= ~c_hi;
                io.ovf  <= (s1_a_hi[HI-1] != s1_b_hi[HI-1]) && (d_hi[HI-1] != s1_a_hi[HI-1]);
                io.zero <= (d_full == '0);
            end
        end
    end

    // Stage-1 payload is meaningful only while s1_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_d_lo   <= d_lo;
            s1_borrow <= ~c_lo;
            s1_a_hi   <= io.a[M-1:LO];
            s1_b_hi   <= io.b[M-1:LO];
        end
    end
endmodule

// File: tb/tb_cla_sub_pipe.sv
// Randomised and directed bench for cla_sub_pipe against an arithmetic reference model.
module tb_cla_sub_pipe;
    localparam int M = 17;

    logic clk;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_acc   = 0;
    int   n_out   = 0;

    logic [M+1:0] exp_q[$];
    bit           hold = 0;
    logic [M-1:0] h_diff;
    logic [2:0]   h_flags;

    cla_sub_pipe_if #(.M(M)) io();

    cla_sub_pipe #(.M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // {ovf, bout, diff} from plain integer arithmetic.
    function automatic logic [M+1:0] model(input logic [M-1:0] a, input logic [M-1:0] b, input logic bi);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint ib = longint'(bi);
        longint sa = a[M-1] ? ua - (longint'(1) << M) : ua;
        longint sb = b[M-1] ? ub - (longint'(1) << M) : ub;
        longint d  = ua - ub - ib;
        longint sd = sa - sb - ib;
        logic   bo = (ua < ub + ib);
        logic   ov = (sd < -(longint'(1) << (M-1))) || (sd > (longint'(1) << (M-1)) - 1);
        logic [M-1:0] dd = d[M-1:0];
        return {ov, bo, dd};
    endfunction

    function automatic logic [M-1:0] rand_op();
        logic [M-1:0] r = M'($urandom);
        case ($urandom % 5)
            0: r = '0;
            1: r = '1;
            2: r = {1'b1, {(M-1){1'b0}}};
            3: r = {1'b0, {(M-1){1'b1}}};
            default: ;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        logic [M+1:0] e;
        if (!rst_n) begin
            exp_q.delete();
            hold = 0;
        end else begin
            if (hold) begin
                chk("hold_valid", io.out_valid, 1);
                chk("hold_diff", io.diff, h_diff);
                chk("hold_flags", {io.bout, io.ovf, io.zero}, h_flags);
            end
            if (io.out_valid && io.out_ready) begin
                chk("result_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("diff", io.diff, e[M-1:0]);
                    chk("bout", io.bout, e[M]);
                    chk("ovf", io.ovf, e[M+1]);
                    chk("zero", io.zero, e[M-1:0] == '0);
                    n_out++;
                end
            end
            if (io.in_valid && io.in_ready) begin
                exp_q.push_back(model(io.a, io.b, io.bin));
                n_acc++;
            end
            hold    = io.out_valid && !io.out_ready;
            h_diff  = io.diff;
            h_flags = {io.bout, io.ovf, io.zero};
        end
    end

    task automatic do_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic bi);
        bit ok = 0;
        io.a        = a;
        io.b        = b;
        io.bin      = bi;
        io.in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = io.in_ready;
            @(posedge clk);
            #1;
        end
        chk("accept_in_time", ok, 1);
    endtask

    task automatic directed(input logic [M-1:0] a, input logic [M-1:0] b, input logic bi,
                            input logic [M-1:0] ed, input logic eb, input logic eo);
        logic [M+1:0] m = model(a, b, bi);
        chk("model_diff", m[M-1:0], ed);
        chk("model_bout", m[M], eb);
        chk("model_ovf", m[M+1], eo);
        io.out_ready = 1'b1;
        do_op(a, b, bi);
        io.in_valid = 1'b0;
        chk("lat_not_early", io.out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_valid", io.out_valid, 1);
        chk("dir_diff", io.diff, ed);
        chk("dir_bout", io.bout, eb);
        chk("dir_ovf", io.ovf, eo);
        chk("dir_zero", io.zero, ed == '0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || io.out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        chk("drained", exp_q.size(), 0);
    endtask

    initial begin
        int  acc0;
        int  out0;
        bit  acc;
        io.in_valid  = 1'b0;
        io.a         = '0;
        io.b         = '0;
        io.bin       = 1'b0;
        io.out_ready = 1'b1;
        rst_n        = 1'b0;
        #1;
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_in_ready", io.in_ready, 1);
        chk("rst_diff", io.diff, 0);
        chk("rst_flags", {io.bout, io.ovf, io.zero}, 0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed(17'd100,   17'd58,    1'b0, 17'd42,    1'b0, 1'b0);
        directed(17'd0,     17'd1,     1'b0, 17'h1FFFF, 1'b1, 1'b0);
        directed(17'h0ABCD, 17'h0ABCD, 1'b1, 17'h1FFFF, 1'b1, 1'b0);
        directed(17'h00100, 17'h00001, 1'b0, 17'h000FF, 1'b0, 1'b0);
        directed(17'h12345, 17'h12345, 1'b0, 17'h00000, 1'b0, 1'b0);
        directed(17'h10000, 17'h00001, 1'b0, 17'h0FFFF, 1'b0, 1'b1);
        directed(17'h0FFFF, 17'h1FFFF, 1'b0, 17'h10000, 1'b1, 1'b1);

        // Random traffic with random bubbles and backpressure.
        acc = 0;
        io.in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!io.in_valid || acc) begin
                io.in_valid = ($urandom % 4) != 0;
                io.a        = rand_op();
                io.b        = (($urandom % 5) == 0) ? io.a : rand_op();
                io.bin      = 1'($urandom % 2);
            end
            io.out_ready = ($urandom % 3) != 0;
            @(negedge clk);
            acc = io.in_valid && io.in_ready;
            @(posedge clk);
            #1;
        end
        drain();

        // Six back-to-back ops with a four-cycle stall after the first result.
        acc0 = n_acc;
        out0 = n_out;
        io.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) do_op(rand_op(), rand_op(), 1'($urandom % 2));
                io.in_valid = 1'b0;
            end
            begin
                bit seen = 0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(posedge clk);
                    #1;
                    seen = io.out_valid;
                end
                chk("bp_first_out", seen, 1);
                io.out_ready = 1'b0;
                @(negedge clk);
                chk("bp_in_ready_low", io.in_ready, 0);
                chk("bp_accepted_two", n_acc - acc0, 2);
                repeat (4) @(posedge clk);
                #1;
                io.out_ready = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    chk("bp_throughput", io.out_valid, 1);
                end
            end
        join
        drain();
        chk("bp_results_out", n_out - out0, 6);

        // Reset with both stages full and the output stalled.
        io.out_ready = 1'b0;
        do_op(17'h01234, 17'h00321, 1'b0);
        do_op(17'h1F000, 17'h00FFF, 1'b1);
        io.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", io.out_valid, 0);
        chk("async_diff", io.diff, 0);
        chk("async_flags", {io.bout, io.ovf, io.zero}, 0);
        chk("async_in_ready", io.in_ready, 1);
        @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_no_stale", io.out_valid, 0);
        directed(17'd7, 17'd3, 1'b0, 17'd4, 1'b0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
